// File: rtl/inference_if.sv
// Bus between the inference core, its weight/bias/pixel memories and the
// loader/display logic around it.
interface inference_if;
    // Memories are synchronous: *_data is valid the cycle after *_addr.
    // start_inference is a level request sampled only while busy is low;
    // inference_done is a one-cycle pulse with predicted_digit already valid.
    logic [12:0] weight_addr;
    logic [7:0]  weight_data;
    logic [3:0]  bias_addr;
    logic [31:0] bias_data;
    logic        weights_ready;
    logic        start_inference;
    logic [7:0]  input_pixel;
    logic [9:0]  input_addr;
    logic [3:0]  predicted_digit;
    logic        inference_done;
    logic        busy;
    logic [2:0]  dbg_state;

    modport master (
        output weight_addr, bias_addr, input_addr,
        output predicted_digit, inference_done, busy, dbg_state,
        input  weight_data, bias_data, input_pixel,
        input  weights_ready, start_inference
    );

    modport slave (
        input  weight_addr, bias_addr, input_addr,
        input  predicted_digit, inference_done, busy, dbg_state,
        output weight_data, bias_data, input_pixel,
        output weights_ready, start_inference
    );
endinterface

// File: rtl/inference.sv
// Sequential argmax classifier: for each of 10 classes, accumulates
// sum(w*x) over 784 pixels, adds the class bias and keeps the best score.
module inference #(
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_CLASSES = 10
) (
    input  logic        clk,
    input  logic        rst,
    inference_if.master bus
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_BIAS  = 3'd1,
        COMPUTE    = 3'd2,
        ADD_BIAS   = 3'd3,
        COMPARE    = 3'd4,
        NEXT_CLASS = 3'd5,
        DONE       = 3'd6
    } state_t;

    state_t             state;
    logic signed [31:0] accumulator;
    logic signed [31:0] score;
    logic signed [31:0] max_score;
    logic [3:0]         current_class;
    logic [3:0]         max_class;
    logic [9:0]         current_pixel;

    logic               r_valid_d;
    logic [12:0]        r_weight_addr;
    logic [3:0]         r_bias_addr;
    logic [9:0]         r_input_addr;
    logic [3:0]         r_predicted;
    logic               r_done;
    logic               r_busy;

    logic signed [16:0] w_weight_ext;
    logic signed [16:0] w_pixel_ext;
    logic signed [16:0] w_product;
    logic signed [31:0] w_product_ext;
    logic [12:0]        w_class_base;
    logic               w_last_class;
    logic               w_addr_in_range;
    logic               w_addr_last;

    // Signed weight times zero-extended pixel; the true product fits in 17 bits.
    assign w_weight_ext    = {{9{bus.weight_data[7]}}, bus.weight_data};
    assign w_pixel_ext     = {9'd0, bus.input_pixel};
    assign w_product       = w_weight_ext * w_pixel_ext;
    assign w_product_ext   = {{15{w_product[16]}}, w_product};

    assign w_class_base    = {9'd0, current_class} * 13'd784;
    assign w_last_class    = (current_class == 4'(NUM_CLASSES - 1));
    assign w_addr_in_range = (current_pixel < 10'(NUM_INPUTS));
    assign w_addr_last     = (current_pixel == 10'(NUM_INPUTS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            accumulator   <= '0;
            score         <= '0;
            max_score     <= '0;
            current_class <= '0;
            max_class     <= '0;
            current_pixel <= '0;
            r_valid_d     <= 1'b0;
            r_weight_addr <= '0;
            r_bias_addr   <= '0;
            r_input_addr  <= '0;
            r_predicted   <= '0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (state)
                IDLE: begin
                    r_weight_addr <= '0;
                    r_input_addr  <= '0;
                    r_bias_addr   <= '0;
                    if (bus.start_inference && bus.weights_ready) begin
                        state         <= LOAD_BIAS;
                        current_class <= '0;
                        r_bias_addr   <= '0;
                        r_busy        <= 1'b1;
                    end
                end

                LOAD_BIAS: begin
                    accumulator   <= '0;
                    current_pixel <= '0;
                    r_valid_d     <= 1'b0;
                    r_weight_addr <= w_class_base;
                    r_input_addr  <= '0;
                    state         <= COMPUTE;
                end

                // Addresses lead the data by one cycle; r_valid_d marks the
                // cycles where the memories return a real operand pair.
                COMPUTE: begin
                    r_valid_d <= w_addr_in_range;
                    if (r_valid_d) begin
                        accumulator <= accumulator + w_product_ext;
                    end
                    if (w_addr_in_range && !w_addr_last) begin
                        r_weight_addr <= r_weight_addr + 13'd1;
                        r_input_addr  <= r_input_addr + 10'd1;
                    end else begin
                        r_weight_addr <= '0;
                        r_input_addr  <= '0;
                    end
                    if (current_pixel == 10'(NUM_INPUTS)) begin
                        state <= ADD_BIAS;
                    end else begin
                        current_pixel <= current_pixel + 10'd1;
                    end
                end

                ADD_BIAS: begin
                    score <= accumulator + $signed(bus.bias_data);
                    state <= COMPARE;
                end

                COMPARE: begin
                    if ((current_class == 4'd0) || (score > max_score)) begin
                        max_score <= score;
                        max_class <= current_class;
                    end
                    state <= NEXT_CLASS;
                end

                NEXT_CLASS: begin
                    if (w_last_class) begin
                        r_predicted <= max_class;
                        r_done      <= 1'b1;
                        r_bias_addr <= '0;
                        state       <= DONE;
                    end else begin
                        current_class <= current_class + 4'd1;
                        r_bias_addr   <= current_class + 4'd1;
                        state         <= LOAD_BIAS;
                    end
                end

                DONE: begin
                    r_busy <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    r_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.weight_addr     = r_weight_addr;
    assign bus.bias_addr       = r_bias_addr;
    assign bus.input_addr      = r_input_addr;
    assign bus.predicted_digit = r_predicted;
    assign bus.inference_done  = r_done;
    assign bus.busy            = r_busy;
    assign bus.dbg_state       = state;

endmodule

// File: tb/tb_inference.sv
// Bench for the argmax classifier: memory models, directed and random images,
// a reference model computing the scores directly, and a done-pulse monitor.
module tb_inference;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inference_if bus();

  inference dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  wmem [0:7839];
  logic [31:0] bmem [0:9];
  logic [7:0]  pmem [0:783];

  // synchronous memories: data one cycle after address
  always @(posedge clk) begin
    bus.weight_data <= wmem[bus.weight_addr];
    bus.bias_data   <= bmem[bus.bias_addr];
    bus.input_pixel <= pmem[bus.input_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  logic [3:0] exp_q[$];
  int start_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: score per class from plain integer arithmetic, strict-greater argmax
  function automatic logic [3:0] ref_digit();
    int best = 0;
    int best_c = 0;
    for (int c = 0; c < 10; c++) begin
      int s = int'(bmem[c]);
      for (int p = 0; p < 784; p++)
        s += int'($signed(wmem[c*784+p])) * int'(pmem[p]);
      if (c == 0 || s > best) begin
        best = s;
        best_c = c;
      end
    end
    return 4'(best_c);
  endfunction

  // Monitor: every done pulse is matched against the expected queue
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (prev_done) begin
        check("done_pulse_width", {31'd0, bus.inference_done}, 32'd0);
        check("busy_after_done", {31'd0, bus.busy}, 32'd0);
      end
      if (bus.inference_done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [3:0] e;
          int t0;
          e  = exp_q.pop_front();
          t0 = start_q.pop_front();
          check("predicted_digit", {28'd0, bus.predicted_digit}, {28'd0, e});
          check("done_latency", cyc - t0, 32'd7890);
          check("busy_in_done", {31'd0, bus.busy}, 32'd1);
        end
      end
      prev_done = bus.inference_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic start_run(input bit expect_done);
    logic [3:0] e;
    e = ref_digit();
    @(negedge clk);
    bus.start_inference = 1'b1;
    @(posedge clk);
    #1;
    bus.start_inference = 1'b0;
    if (expect_done) begin
      exp_q.push_back(e);
      start_q.push_back(cyc);
    end
  endtask

  task automatic wait_done(input string name);
    int n0 = n_done;
    int t = 0;
    while (n_done == n0 && t < 9000) begin
      @(negedge clk);
      t++;
    end
    check(name, n_done - n0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic fill(input int wmode, input int pmode, input int bmode);
    for (int i = 0; i < 7840; i++) begin
      case (wmode)
        0: wmem[i] = 8'd0;
        1: wmem[i] = (i / 784 == 3) ? 8'd1 : 8'd0;
        2: wmem[i] = 8'h80;
        default: wmem[i] = 8'($urandom_range(0, 255));
      endcase
    end
    for (int p = 0; p < 784; p++) begin
      case (pmode)
        0: pmem[p] = 8'd0;
        1: pmem[p] = 8'd255;
        default: pmem[p] = 8'($urandom_range(0, 255));
      endcase
    end
    for (int c = 0; c < 10; c++) begin
      case (bmode)
        0: bmem[c] = 32'(c * 1000);
        1: bmem[c] = 32'd12345;
        2: bmem[c] = 32'd0;
        3: bmem[c] = (c == 5) ? 32'd1 : 32'd0;
        default: bmem[c] = 32'($urandom_range(0, 400000)) - 32'd200000;
      endcase
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.start_inference = 1'b0;
    bus.weights_ready = 1'b0;
    fill(0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_state", {29'd0, bus.dbg_state}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.inference_done}, 32'd0);
    check("reset_digit", {28'd0, bus.predicted_digit}, 32'd0);
    check("reset_waddr", {19'd0, bus.weight_addr}, 32'd0);
    check("reset_baddr", {28'd0, bus.bias_addr}, 32'd0);
    check("reset_iaddr", {22'd0, bus.input_addr}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // start without weights_ready is ignored
    start_run(1'b0);
    repeat (20) @(negedge clk);
    check("no_ready_busy", {31'd0, bus.busy}, 32'd0);
    check("no_ready_state", {29'd0, bus.dbg_state}, 32'd0);
    check("no_ready_done_count", n_done, 32'd0);

    bus.weights_ready = 1'b1;

    // zero weights, bias c*1000 -> class 9
    fill(0, 0, 0);
    start_run(1'b1);
    repeat (5) @(negedge clk);
    check("busy_running", {31'd0, bus.busy}, 32'd1);
    wait_done("timeout_bias_ramp");
    check("idle_waddr", {19'd0, bus.weight_addr}, 32'd0);

    // all scores tie -> lowest index wins
    fill(0, 4, 1);
    start_run(1'b1);
    wait_done("timeout_tie");

    // only class 3 sees the image
    fill(1, 1, 2);
    start_run(1'b1);
    wait_done("timeout_class3");

    // large negative scores, bias tips class 5; mid-run start and ready drop
    fill(2, 1, 3);
    begin
      int n0;
      n0 = n_done;
      start_run(1'b1);
      repeat (3000) @(negedge clk);
      bus.start_inference = 1'b1;
      bus.weights_ready = 1'b0;
      @(negedge clk);
      bus.start_inference = 1'b0;
      bus.weights_ready = 1'b1;
      wait_done("timeout_negative");
      repeat (20) @(negedge clk);
      check("single_done_pulse", n_done - n0, 32'd1);
    end

    // reset in the middle of COMPUTE
    fill(3, 4, 4);
    check("digit_before_abort", {28'd0, bus.predicted_digit}, 32'd5);
    start_run(1'b0);
    repeat (1500) @(negedge clk);
    check("abort_pre_state", {29'd0, bus.dbg_state}, 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_state", {29'd0, bus.dbg_state}, 32'd0);
    check("abort_digit", {28'd0, bus.predicted_digit}, 32'd0);
    check("abort_waddr", {19'd0, bus.weight_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    start_run(1'b1);
    wait_done("timeout_after_abort");

    // random images
    for (int r = 0; r < 2; r++) begin
      fill(3, 4, 4);
      start_run(1'b1);
      wait_done("timeout_random");
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inference.md
Name: inference

Overview:
- Sequential argmax classifier for a 10-class linear model (MNIST logistic regression) over a 784-pixel (28x28) image.
- Reads weights, biases and pixels from external synchronous memories, one word per cycle.
- For each class, computes score = sum(w*x) + bias.
- Reports the index of the highest score as predicted_digit.
- Sits between the weight/bias loader (which signals weights_ready) and the result display/UART logic.

Parameters:
- NUM_INPUTS, 784, pixels per image. Fixed; port widths are sized for this value.
- NUM_CLASSES, 10, output classes. Fixed; port widths are sized for this value.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low: rst=0 resets immediately; release is synchronous to clk.
- weight_addr  out  13  weight RAM address = class*784 + pixel (range 0..7839).
- weight_data  in  8  signed two's-complement weight; valid 1 cycle after weight_addr.
- bias_addr  out  4  bias RAM address = current class (0..9).
- bias_data  in  32  signed bias; valid 1 cycle after bias_addr.
- weights_ready  in  1  weights and biases are loaded; start is ignored while 0.
- start_inference  in  1  start request, sampled only in IDLE.
- input_pixel  in  8  unsigned pixel value; valid 1 cycle after input_addr.
- input_addr  out  10  pixel index (0..783).
- predicted_digit  out  4  argmax class. Holds its value until the next completion.
- inference_done  out  1  one-cycle pulse on completion.
- busy  out  1  high in every state except IDLE.

Behaviour:
- State encoding (3 bits, internal register "state"):
  - IDLE=0, LOAD_BIAS=1, COMPUTE=2, ADD_BIAS=3, COMPARE=4, NEXT_CLASS=5, DONE=6.
- Required internal registers: accumulator (32-bit signed), current_class (4-bit), current_pixel (10-bit), score, max_score, max_class.
- Reset: state=IDLE. All of the following are 0: accumulator, counters, addresses, predicted_digit, inference_done, busy, max registers.
- IDLE: if start_inference && weights_ready → LOAD_BIAS, with current_class=0.
- LOAD_BIAS (1 cycle):
  - accumulator←0, current_pixel←0.
  - bias_addr=current_class; it stays stable through ADD_BIAS.
  - → COMPUTE.
- COMPUTE (785 cycles per class):
  - In cycle k (k=0..783), drive input_addr=k and weight_addr=class*784+k.
  - In cycle k+1, accumulate: accumulator += sext32(weight_data * {1'b0,input_pixel}), a signed 8x9 product.
  - Use a 1-cycle-delayed valid flag to gate accumulation, so nothing is accumulated in the first cycle.
  - Leave for ADD_BIAS after product 783 has been accumulated.
- ADD_BIAS (1 cycle):
  - score←accumulator+bias_data, signed 32-bit with wrap on overflow.
  - accumulator itself is not modified.
- COMPARE (1 cycle): if current_class==0 or score > max_score (signed, strict), then max_score←score and max_class←current_class. Ties keep the lower index.
- NEXT_CLASS:
  - If current_class==9: predicted_digit←max_class, → DONE.
  - Otherwise: current_class+1, → LOAD_BIAS.
- DONE (1 cycle):
  - inference_done=1 and busy=1; predicted_digit is already valid.
  - → IDLE; inference_done returns to 0.
- Timing: 789 cycles per class. DONE is entered 7890 cycles after the edge that sampled start.
- start_inference during a run is ignored; there is no restart.
- weights_ready dropping mid-run does not abort the run.
- Asserting rst mid-run aborts immediately to the reset state. The stale predicted_digit is cleared to 0.
- Addresses in IDLE/DONE: 0.

Test Plan:
- All weights=0, all pixels=0, bias[c]=c*1000 → accumulator stays 0 throughout COMPUTE and ADD_BIAS; predicted_digit=9; inference_done pulses exactly 1 cycle; busy low afterwards.
- Weights=0, biases equal, pixels random → tie on every score; predicted_digit=0.
- Weight[3*784+p]=+1, all other weights=0, pixels=255, biases=0 → class 3 score=199920; predicted_digit=3.
- All weights=-128, pixels=255, biases 0 except bias[5]=1 → scores of -25589760 for all classes except class 5 (-25589759); predicted_digit=5 (exercises the signed product and signed compare).
- start_inference with weights_ready=0 → stays IDLE, busy=0; start pulsed mid-run → ignored, single done pulse at cycle 7890.
- rst=0 in the middle of COMPUTE → busy=0 and state=IDLE immediately; a fresh start afterwards completes correctly.
